// File: rtl/fft_in_framer_if.sv
// Sample stream feeding the FFT input framer: one complex sample per beat
// with valid/ready handshake and an end-of-frame marker.
interface fft_in_framer_if #(
  parameter int WIDTH_IN = 9
);
  logic                s_valid;
  logic                s_ready;
  logic [WIDTH_IN-1:0] s_i;
  logic [WIDTH_IN-1:0] s_q;
  logic                s_last;

  modport master (output s_valid, s_i, s_q, s_last, input s_ready);
  modport slave  (input s_valid, s_i, s_q, s_last, output s_ready);
endinterface

// File: rtl/fft_in_framer.sv
// Ping-pong framer: collects N_POINT samples per bank and replays each frame as a
// gapless BEATS-long burst of ARRAY_IN stride-decimated lanes. Optional FRAMER_LAST_CHECK_EN.
//
// state | meaning
// IDLE  | no beat on din, waiting for a full bank
// BURST | presenting beat rd_beat of bank rd_bank on din
module fft_in_framer #(
  parameter int WIDTH_IN = 9,
  parameter int ARRAY_IN = 16,
  parameter int N_POINT  = 512
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  fft_in_framer_if.slave                       s,
  output logic                                 din_valid,
  output logic [0:ARRAY_IN-1][WIDTH_IN-1:0]    din_i,
  output logic [0:ARRAY_IN-1][WIDTH_IN-1:0]    din_q,
  output logic                                 frame_err
);

  localparam int BEATS  = N_POINT / ARRAY_IN;
  localparam int ADDR_W = $clog2(N_POINT);
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state;
  logic [BEAT_W-1:0]   rd_beat;
  logic                rd_bank;
  logic [1:0]          full;
  logic [ADDR_W-1:0]   wr_cnt;
  logic                wr_bank;

  logic [WIDTH_IN-1:0] mem_i [2][N_POINT];
  logic [WIDTH_IN-1:0] mem_q [2][N_POINT];

  logic                accept;
  logic                at_end;
  logic                lane_err;
  logic                frame_done;
  logic                last_beat;
  logic [1:0]          full_set;
  logic [1:0]          full_avail;
  logic                load;
  logic                load_bank;
  logic [BEAT_W-1:0]   load_beat;
  logic [0:ARRAY_IN-1][WIDTH_IN-1:0] beat_i;
  logic [0:ARRAY_IN-1][WIDTH_IN-1:0] beat_q;

  assign accept    = s.s_valid && s.s_ready;
  assign at_end    = (wr_cnt == ADDR_W'(N_POINT - 1));
  assign s.s_ready = !full[wr_bank];
  assign last_beat = (state == BURST) && (rd_beat == BEAT_W'(BEATS - 1));

`ifdef FRAMER_LAST_CHECK_EN
  assign lane_err = accept && (s.s_last != at_end);
`else
  assign lane_err = 1'b0;
`endif

  assign frame_done = accept && at_end && !lane_err;

  // Next beat is chosen against the post-update full[] so a frame completing
  // this cycle starts its burst on the very next cycle.
  always_comb begin
    full_set = full;
    if (frame_done) full_set[wr_bank] = 1'b1;
    full_avail = full_set;
    if (last_beat) full_avail[rd_bank] = 1'b0;

    load      = 1'b0;
    load_bank = rd_bank;
    load_beat = rd_beat + BEAT_W'(1);
    if (state == BURST && !last_beat) begin
      load = 1'b1;
    end else if (last_beat) begin
      load      = full_avail[!rd_bank];
      load_bank = !rd_bank;
      load_beat = '0;
    end else if (|full_avail) begin
      load      = 1'b1;
      load_bank = !full_avail[0];
      load_beat = '0;
    end
  end

  always_comb begin
    beat_i = '0;
    beat_q = '0;
    for (int k = 0; k < ARRAY_IN; k++) begin
      beat_i[k] = mem_i[load_bank][ADDR_W'(k * BEATS + int'(load_beat))];
      beat_q[k] = mem_q[load_bank][ADDR_W'(k * BEATS + int'(load_beat))];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !lane_err) begin
      mem_i[wr_bank][wr_cnt] <= s.s_i;
      mem_q[wr_bank][wr_cnt] <= s.s_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_beat   <= '0;
      rd_bank   <= 1'b0;
      full      <= '0;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      din_valid <= 1'b0;
      din_i     <= '0;
      din_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_avail;
      frame_err <= lane_err;
      if (lane_err) begin
        wr_cnt <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
        if (at_end) wr_bank <= !wr_bank;
      end

      din_valid <= load;
      if (load) begin
        state   <= BURST;
        rd_bank <= load_bank;
        rd_beat <= load_beat;
        din_i   <= beat_i;
        din_q   <= beat_q;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fft_in_framer.sv
// Self-checking bench for fft_in_framer: frame-level reference model compared every
// cycle, plus literal expectations for the ramp frame and burst timing.
module tb_fft_in_framer;

  localparam int W     = 9;
  localparam int LANES = 16;
  localparam int NPT   = 512;
  localparam int BEATS = NPT / LANES;

  logic clk;
  logic rstn;
  logic din_valid;
  logic [0:LANES-1][W-1:0] din_i;
  logic [0:LANES-1][W-1:0] din_q;
  logic frame_err;

  fft_in_framer_if #(.WIDTH_IN(W)) sif ();

  fft_in_framer #(.WIDTH_IN(W), .ARRAY_IN(LANES), .N_POINT(NPT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s         (sif),
    .din_valid (din_valid),
    .din_i     (din_i),
    .din_q     (din_q),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [W*LANES-1:0] got, input logic [W*LANES-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int smp_i(input int f, input int n);
    if (f == 0) return n - 256;
    return ((n * 5 + f * 97) % 512) - 256;
  endfunction

  function automatic int smp_q(input int f, input int n);
    if (f == 0) return 255 - n;
    return ((n * 13 + f * 41 + 7) % 512) - 256;
  endfunction

  // Reference model: frames as sample lists, bursts replayed from a FIFO of completed frames.
  int cur_i [NPT];
  int cur_q [NPT];
  int cur_n;
  int pend_i [$];
  int pend_q [$];
  int act_i [NPT];
  int act_q [NPT];
  bit act;
  int beat;
  int last_i [LANES];
  int last_q [LANES];
  bit exp_err;
  logic [0:LANES-1][W-1:0] ei, eq;

  int rise_q [$];
  int len_q [$];
  int run;
  int err_cnt;
  logic [0:LANES-1][W-1:0] cap0_i, cap0_q, cap31_i, cap31_q;

  task automatic model_reset();
    cur_n = 0;
    pend_i.delete();
    pend_q.delete();
    act = 1'b0;
    beat = 0;
    exp_err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      last_i[k] = 0;
      last_q[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
    end else begin
      if (act) begin
        beat++;
        if (beat == BEATS) act = 1'b0;
      end
      if (!act && pend_i.size() >= NPT) begin
        for (int j = 0; j < NPT; j++) begin
          act_i[j] = pend_i.pop_front();
          act_q[j] = pend_q.pop_front();
        end
        act = 1'b1;
        beat = 0;
      end
    end
    if (act) begin
      for (int k = 0; k < LANES; k++) begin
        last_i[k] = act_i[k * BEATS + beat];
        last_q[k] = act_q[k * BEATS + beat];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      ei[k] = W'(last_i[k]);
      eq[k] = W'(last_q[k]);
    end

    chk_int("din_valid", int'(din_valid), int'(act));
    chk_vec("din_i", din_i, ei);
    chk_vec("din_q", din_q, eq);
    chk_int("frame_err", int'(frame_err), int'(exp_err));
    if (rstn) chk_int("s_ready", int'(sif.s_ready), int'((pend_i.size() / NPT + int'(act)) < 2));

    exp_err = 1'b0;
    if (rstn && sif.s_valid && sif.s_ready) begin
`ifdef FRAMER_LAST_CHECK_EN
      if (sif.s_last != (cur_n == NPT - 1)) begin
        exp_err = 1'b1;
        cur_n = 0;
      end else begin
`else
      begin
`endif
        cur_i[cur_n] = int'($signed(sif.s_i));
        cur_q[cur_n] = int'($signed(sif.s_q));
        cur_n++;
        if (cur_n == NPT) begin
          for (int j = 0; j < NPT; j++) begin
            pend_i.push_back(cur_i[j]);
            pend_q.push_back(cur_q[j]);
          end
          cur_n = 0;
        end
      end
    end

    // Observed burst shape, pinned against literal expectations by the main sequence.
    if (frame_err === 1'b1) err_cnt++;
    if (din_valid === 1'b1) begin
      run++;
      if (run == 1) begin
        rise_q.push_back(cyc);
        cap0_i = din_i;
        cap0_q = din_q;
      end
      if (run == BEATS) begin
        cap31_i = din_i;
        cap31_q = din_q;
      end
    end else if (run > 0) begin
      len_q.push_back(run);
      run = 0;
    end
  end

  task automatic send(input int f, input int cnt, input bit gap, input int last_at, output int last_cyc);
    last_cyc = 0;
    for (int n = 0; n < cnt; n++) begin
      sif.s_valid = 1'b1;
      sif.s_i     = W'(smp_i(f, n));
      sif.s_q     = W'(smp_q(f, n));
      sif.s_last  = (n == last_at);
      last_cyc    = cyc;
      @(posedge clk); #1;
      if (gap) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        @(posedge clk); #1;
      end
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rise_q.delete();
    len_q.delete();
    err_cnt = 0;
  endtask

  int lc, lc1, lc2, lc3;

  initial begin
    rstn = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_i = '0;
    sif.s_q = '0;
    sif.s_last = 1'b0;
    run = 0;
    err_cnt = 0;
    model_reset();

    repeat (5) @(posedge clk);
    #1;
    chk_int("reset din_valid", int'(din_valid), 0);
    chk_int("reset frame_err", int'(frame_err), 0);
    chk_vec("reset din_i", din_i, '0);
    chk_vec("reset din_q", din_q, '0);
    rstn = 1'b1;
    idle(1);
    chk_int("ready after reset", int'(sif.s_ready), 1);

    // Ramp frame
    clear_obs();
    send(0, NPT, 1'b0, NPT - 1, lc);
    idle(40);
    chk_int("ramp bursts", rise_q.size(), 1);
    if (rise_q.size() == 1) chk_int("ramp start", rise_q[0], lc + 1);
    if (len_q.size() == 1) chk_int("ramp len", len_q[0], BEATS);
    else chk_int("ramp len count", len_q.size(), 1);
    chk_int("b0 l0 i", int'($signed(cap0_i[0])), -256);
    chk_int("b0 l0 q", int'($signed(cap0_q[0])), 255);
    chk_int("b0 l1 i", int'($signed(cap0_i[1])), -224);
    chk_int("b31 l15 i", int'($signed(cap31_i[15])), 255);
    chk_int("b31 l15 q", int'($signed(cap31_q[15])), -256);

    // Back-to-back frames
    clear_obs();
    send(1, NPT, 1'b0, NPT - 1, lc1);
    send(2, NPT, 1'b0, NPT - 1, lc2);
    send(3, NPT, 1'b0, NPT - 1, lc3);
    idle(40);
    chk_int("b2b bursts", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk_int("b2b start0", rise_q[0], lc1 + 1);
      chk_int("b2b spacing01", rise_q[1] - rise_q[0], 512);
      chk_int("b2b spacing12", rise_q[2] - rise_q[1], 512);
    end
    for (int b = 0; b < len_q.size(); b++) chk_int("b2b len", len_q[b], BEATS);

    // Gapped input
    clear_obs();
    send(5, NPT, 1'b1, NPT - 1, lc);
    idle(40);
    chk_int("gap bursts", rise_q.size(), 1);
    if (rise_q.size() == 1) chk_int("gap start", rise_q[0], lc + 1);
    if (len_q.size() == 1) chk_int("gap len", len_q[0], BEATS);

    // Mid-frame reset
    clear_obs();
    send(9, 300, 1'b0, -1, lc);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);
    chk_int("mrst no burst", rise_q.size(), 0);
    send(4, NPT, 1'b0, NPT - 1, lc);
    idle(40);
    chk_int("mrst bursts", rise_q.size(), 1);
    if (rise_q.size() == 1) chk_int("mrst start", rise_q[0], lc + 1);

`ifdef FRAMER_LAST_CHECK_EN
    clear_obs();
    send(6, 101, 1'b0, 100, lc);
    idle(40);
    chk_int("early last err", err_cnt, 1);
    chk_int("early last no burst", rise_q.size(), 0);
    send(7, NPT, 1'b0, NPT - 1, lc);
    idle(40);
    chk_int("clean frame err", err_cnt, 1);
    chk_int("clean frame bursts", rise_q.size(), 1);
    if (rise_q.size() == 1) chk_int("clean frame start", rise_q[0], lc + 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
